alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 CLK  input  1  single clock; all state updates on its rising edge.
REQ-002 RESET  input  1  reset, synchronous and active-high; sampled only on the rising edge of CLK.
REQ-003 OP  input  4  operation select (encoding in REQ-012).
REQ-004 INPUTA  input  16  primary operand / shift source.
REQ-005 INPUTB  input  16  secondary operand.
REQ-006 INPUTC  input  16  funnel-shift fill source for kSLG/kSRG.
REQ-007 INPUTD  input  4  shift amount, 0..15.
REQ-008 CI  input  1  carry/borrow in for kADD/kSUB.
REQ-009 OUT  output  16  registered result.
REQ-010 ZERO  output  1  registered flag, 1 when the registered OUT is 0x0000.
REQ-011 EQUAL  output  1  registered flag, 1 when INPUTA == INPUTB at the capturing edge; independent of OP.
REQ-011a CO  output  1  registered carry/borrow/shift-out flag.

Function
REQ-012 OP encoding SHALL be: 0 kADD, 1 kSUB, 2 kSLL, 3 kSRL, 4 kSRA, 5 kGT, 6 kLT, 7 kSLG, 8 kSRG, 9 kSLO, 10 kSRO, 11 kNEG, 12-15 reserved.
REQ-013 Latency SHALL be one cycle: inputs sampled on rising edge N appear on OUT/ZERO/EQUAL/CO after edge N; outputs hold between edges; no handshake, one new operation accepted every cycle.
REQ-014 kADD: OUT = (A+B+CI) mod 2^16; CO = bit 16 of the 17-bit sum.
REQ-015 kSUB: OUT = (A-B-CI) mod 2^16; CO = 1 when unsigned A < B+CI (borrow), else 0.
REQ-016 kSLL: OUT = A << D, zero fill; CO = last bit shifted out (A[16-D]), 0 when D=0.
REQ-017 kSRL: OUT = A >> D, zero fill; CO = A[D-1], 0 when D=0.
REQ-018 kSRA: OUT = A >> D, fill with A[15]; CO = A[D-1], 0 when D=0.
REQ-019 kGT: OUT = 0x0001 when A > B as signed two's complement, else 0x0000; CO = 0.
REQ-020 kLT: OUT = 0x0001 when A < B signed, else 0x0000; CO = 0.
REQ-021 kSLG: OUT = upper 16 bits of ({A,C} << D); vacated low bits take C[15:16-D]; CO = 0.
REQ-022 kSRG: OUT = lower 16 bits of ({C,A} >> D); vacated high bits take C[D-1:0]; CO = 0.
REQ-023 kSLO: OUT = A << D with vacated bits filled with 1; CO = 0.
REQ-024 kSRO: OUT = A >> D with vacated bits filled with 1; CO = 0.
REQ-025 kNEG: OUT = (0 - A) mod 2^16; 0x8000 maps to 0x8000; CO = 0.
REQ-026 Reserved OP (12-15): OUT = 0x0000, CO = 0; ZERO=1, EQUAL per REQ-011.
REQ-027 D = 0 for every shift op SHALL yield OUT = A unchanged.
REQ-028 ZERO SHALL be computed from the same-cycle result being registered, never from the previous OUT.
REQ-029 CI SHALL affect only kADD and kSUB.

Reset
REQ-030 While RESET is high at a rising edge: OUT = 0x0000, ZERO = 0, EQUAL = 0, CO = 0; inputs ignored.
REQ-031 First edge with RESET low SHALL capture a normal result; reset asserted mid-stream discards the in-flight operation.
REQ-032 Outputs SHALL be X-free from the first reset edge onward.

Verification
REQ-033 Reset held 2 cycles with A=B=0x0004, OP=kADD -> OUT=0, ZERO=0, EQUAL=0, CO=0; next edge after release -> OUT=0x0008, EQUAL=1, ZERO=0.
REQ-034 A=B=0x0004, CI=0: kSUB -> OUT=0, ZERO=1, CO=0; kGT -> 0, ZERO=1; kLT -> 0; kNEG -> 0xFFFC; kADD A=0xFFFF,B=0x0001 -> OUT=0, CO=1, ZERO=1.
REQ-035 Shifts, D=4: kSLL A=0x0004 -> 0x0040; kSRA A=0x8000 -> 0xF800, CO=0; kSRL A=0x000F -> 0x0000, CO=1, ZERO=1; kSLO A=0x0004 -> 0x004F; kSRO A=0x0004 -> 0xF000.
REQ-036 Funnel, A=0x1234, C=0xABCD, D=4: kSLG -> 0x234A; kSRG -> 0xD123; D=0 -> both 0x1234.
REQ-037 Signed compare: A=0xFFFF, B=0x0001: kLT -> 0x0001, kGT -> 0x0000; kSUB A=0, B=0, CI=1 -> OUT=0xFFFF, CO=1.
REQ-038 Back-to-back: OP changed every cycle for all 12 ops -> each result appears exactly one edge after its inputs; reserved OP=13 -> OUT=0, ZERO=1.

Source files
------------

// File: rtl/alu_if.sv
// Operand/result bundle between an ALU and its driver.
// The master side supplies the operation and operands; the slave side returns the registered result and flags.
interface alu_if #(
  parameter int DATA_W = 16
);
  localparam int SH_W = $clog2(DATA_W);

  logic [3:0]        op;
  logic [DATA_W-1:0] inputa;
  logic [DATA_W-1:0] inputb;
  logic [DATA_W-1:0] inputc;
  logic [SH_W-1:0]   inputd;
  logic              ci;
  logic [DATA_W-1:0] out;
  logic              zero;
  logic              equal;
  logic              co;

  modport master (
    output op, inputa, inputb, inputc, inputd, ci,
    input  out, zero, equal, co
  );

  modport slave (
    input  op, inputa, inputb, inputc, inputd, ci,
    output out, zero, equal, co
  );
endinterface

// File: rtl/alu.sv
// Single-cycle 16-bit ALU: arithmetic, signed compare, plain/arith/ones/funnel shifts and negate.
// A new operation is accepted every cycle; results and flags are registered one edge later.
module alu #(
  parameter int DATA_W = 16
) (
  input  logic clk,
  input  logic reset,
  alu_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [3:0] {
    K_ADD = 4'd0,
    K_SUB = 4'd1,
    K_SLL = 4'd2,
    K_SRL = 4'd3,
    K_SRA = 4'd4,
    K_GT  = 4'd5,
    K_LT  = 4'd6,
    K_SLG = 4'd7,
    K_SRG = 4'd8,
    K_SLO = 4'd9,
    K_SRO = 4'd10,
    K_NEG = 4'd11
  } op_e;

  // Left shift through a carry bit: the top bit of the result is the last bit shifted out.
  function automatic logic [DATA_W:0] shl_co(input logic [DATA_W-1:0] a,
                                             input logic [SH_W-1:0]   sh);
    logic [DATA_W:0] ext;
    ext = {1'b0, a};
    return ext << sh;
  endfunction

  // Right shifts carry a guard bit below the LSB so it captures the last bit shifted out.
  function automatic logic [DATA_W:0] shr_co(input logic [DATA_W-1:0] a,
                                             input logic [SH_W-1:0]   sh);
    logic [DATA_W:0] ext;
    ext = {a, 1'b0};
    return ext >> sh;
  endfunction

  function automatic logic [DATA_W:0] sra_co(input logic [DATA_W-1:0] a,
                                             input logic [SH_W-1:0]   sh);
    logic signed [DATA_W:0] ext;
    ext = {a, 1'b0};
    return ext >>> sh;
  endfunction

  function automatic logic [DATA_W-1:0] funnel_left(input logic [DATA_W-1:0] hi,
                                                    input logic [DATA_W-1:0] lo,
                                                    input logic [SH_W-1:0]   sh);
    logic [2*DATA_W-1:0] cat;
    cat = {hi, lo} << sh;
    return cat[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] funnel_right(input logic [DATA_W-1:0] hi,
                                                     input logic [DATA_W-1:0] lo,
                                                     input logic [SH_W-1:0]   sh);
    logic [2*DATA_W-1:0] cat;
    cat = {hi, lo} >> sh;
    return cat[DATA_W-1:0];
  endfunction

  // Ones-fill shifts are the complement of zero-fill shifts of the complement.
  function automatic logic [DATA_W-1:0] slo(input logic [DATA_W-1:0] a,
                                            input logic [SH_W-1:0]   sh);
    return ~((~a) << sh);
  endfunction

  function automatic logic [DATA_W-1:0] sro(input logic [DATA_W-1:0] a,
                                            input logic [SH_W-1:0]   sh);
    return ~((~a) >> sh);
  endfunction

  logic [DATA_W-1:0]        a_p0;
  logic [DATA_W-1:0]        b_p0;
  logic signed [DATA_W-1:0] a_s_p0;
  logic signed [DATA_W-1:0] b_s_p0;
  logic [DATA_W:0]          sum_p0;
  logic [DATA_W:0]          diff_p0;
  logic [DATA_W:0]          sll_p0;
  logic [DATA_W:0]          srl_p0;
  logic [DATA_W:0]          sra_p0;
  logic [DATA_W-1:0]        res_p0;
  logic                     co_p0;
  logic                     zero_p0;
  logic                     equal_p0;

  logic [DATA_W-1:0]        out_p1;
  logic                     co_p1;
  logic                     zero_p1;
  logic                     equal_p1;

  // Stage p0: combinational evaluation of the operands presented this cycle
  assign a_p0   = bus.inputa;
  assign b_p0   = bus.inputb;
  assign a_s_p0 = bus.inputa;
  assign b_s_p0 = bus.inputb;

  // The 17-bit difference wraps negative exactly when A < B + CI, so bit 16 is the borrow.
  assign sum_p0  = {1'b0, a_p0} + {1'b0, b_p0} + {{DATA_W{1'b0}}, bus.ci};
  assign diff_p0 = {1'b0, a_p0} - {1'b0, b_p0} - {{DATA_W{1'b0}}, bus.ci};
  assign sll_p0  = shl_co(a_p0, bus.inputd);
  assign srl_p0  = shr_co(a_p0, bus.inputd);
  assign sra_p0  = sra_co(a_p0, bus.inputd);

  always_comb begin
    res_p0 = '0;
    co_p0  = 1'b0;
    case (op_e'(bus.op))
      K_ADD: begin
        res_p0 = sum_p0[DATA_W-1:0];
        co_p0  = sum_p0[DATA_W];
      end
      K_SUB: begin
        res_p0 = diff_p0[DATA_W-1:0];
        co_p0  = diff_p0[DATA_W];
      end
      K_SLL: begin
        res_p0 = sll_p0[DATA_W-1:0];
        co_p0  = sll_p0[DATA_W];
      end
      K_SRL: begin
        res_p0 = srl_p0[DATA_W:1];
        co_p0  = srl_p0[0];
      end
      K_SRA: begin
        res_p0 = sra_p0[DATA_W:1];
        co_p0  = sra_p0[0];
      end
      K_GT:    res_p0 = {{(DATA_W-1){1'b0}}, (a_s_p0 > b_s_p0)};
      K_LT:    res_p0 = {{(DATA_W-1){1'b0}}, (a_s_p0 < b_s_p0)};
      K_SLG:   res_p0 = funnel_left(a_p0, bus.inputc, bus.inputd);
      K_SRG:   res_p0 = funnel_right(bus.inputc, a_p0, bus.inputd);
      K_SLO:   res_p0 = slo(a_p0, bus.inputd);
      K_SRO:   res_p0 = sro(a_p0, bus.inputd);
      K_NEG:   res_p0 = '0 - a_p0;
      default: begin
        res_p0 = '0;
        co_p0  = 1'b0;
      end
    endcase
  end

  assign zero_p0  = (res_p0 == '0);
  assign equal_p0 = (a_p0 == b_p0);

  // Stage p1: registered result and flags; reset drops any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      out_p1   <= '0;
      co_p1    <= 1'b0;
      zero_p1  <= 1'b0;
      equal_p1 <= 1'b0;
    end else begin
      out_p1   <= res_p0;
      co_p1    <= co_p0;
      zero_p1  <= zero_p0;
      equal_p1 <= equal_p0;
    end
  end

  assign bus.out   = out_p1;
  assign bus.co    = co_p1;
  assign bus.zero  = zero_p1;
  assign bus.equal = equal_p1;
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU: one operation per cycle, each result checked one edge later.
module tb_alu;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SRL = 4'd3, SRA = 4'd4,
                         GT  = 4'd5, LT  = 4'd6, SLG = 4'd7, SRG = 4'd8, SLO = 4'd9,
                         SRO = 4'd10, NEG = 4'd11;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  alu_if #(.DATA_W(16)) bus ();

  alu #(.DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", tag, got, exp);
    end
  endtask

  // Present one operation, clock it in, and sample just after the capturing edge.
  task automatic step(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [3:0] d, input logic ci);
    bus.op     = op;
    bus.inputa = a;
    bus.inputb = b;
    bus.inputc = c;
    bus.inputd = d;
    bus.ci     = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [15:0] out, input logic zero,
                            input logic equal, input logic co);
    chk({tag, ".out"},   bus.out,          out);
    chk({tag, ".zero"},  {15'd0, bus.zero},  {15'd0, zero});
    chk({tag, ".equal"}, {15'd0, bus.equal}, {15'd0, equal});
    chk({tag, ".co"},    {15'd0, bus.co},    {15'd0, co});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;

    step(ADD, 16'h0004, 16'h0004, 16'h0000, 4'd0, 1'b0);
    expect_all("rst1", 16'h0000, 1'b0, 1'b0, 1'b0);
    step(ADD, 16'h0004, 16'h0004, 16'h0000, 4'd0, 1'b0);
    expect_all("rst2", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(ADD, 16'h0004, 16'h0004, 16'h0000, 4'd0, 1'b0);
    expect_all("add_first", 16'h0008, 1'b0, 1'b1, 1'b0);

    // Back-to-back: every step changes the op and checks the result of the previous edge.
    step(SUB, 16'h0004, 16'h0004, 16'h0000, 4'd0, 1'b0);
    expect_all("sub_eq", 16'h0000, 1'b1, 1'b1, 1'b0);
    step(GT,  16'h0004, 16'h0004, 16'h0000, 4'd0, 1'b0);
    expect_all("gt_eq", 16'h0000, 1'b1, 1'b1, 1'b0);
    step(LT,  16'h0004, 16'h0004, 16'h0000, 4'd0, 1'b0);
    expect_all("lt_eq", 16'h0000, 1'b1, 1'b1, 1'b0);
    step(NEG, 16'h0004, 16'h0004, 16'h0000, 4'd0, 1'b0);
    expect_all("neg4", 16'hFFFC, 1'b0, 1'b1, 1'b0);
    step(ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'd0, 1'b0);
    expect_all("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
    step(ADD, 16'h00FF, 16'h0001, 16'h0000, 4'd0, 1'b1);
    expect_all("add_ci", 16'h0101, 1'b0, 1'b0, 1'b0);
    step(SUB, 16'h0005, 16'h0003, 16'h0000, 4'd0, 1'b1);
    expect_all("sub_ci", 16'h0001, 1'b0, 1'b0, 1'b0);
    step(SUB, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b1);
    expect_all("sub_borrow", 16'hFFFF, 1'b0, 1'b1, 1'b1);

    step(SLL, 16'h0004, 16'h0000, 16'h0000, 4'd4, 1'b0);
    expect_all("sll4", 16'h0040, 1'b0, 1'b0, 1'b0);
    step(SLL, 16'h1000, 16'h0000, 16'h0000, 4'd4, 1'b1);
    expect_all("sll_co", 16'h0000, 1'b1, 1'b0, 1'b1);
    step(SLL, 16'h8001, 16'h0000, 16'h0000, 4'd0, 1'b0);
    expect_all("sll_d0", 16'h8001, 1'b0, 1'b0, 1'b0);
    step(SRA, 16'h8000, 16'h0000, 16'h0000, 4'd4, 1'b0);
    expect_all("sra4", 16'hF800, 1'b0, 1'b0, 1'b0);
    step(SRA, 16'h8008, 16'h0000, 16'h0000, 4'd4, 1'b0);
    expect_all("sra_co", 16'hF800, 1'b0, 1'b0, 1'b1);
    step(SRL, 16'h000F, 16'h0000, 16'h0000, 4'd4, 1'b0);
    expect_all("srl4", 16'h0000, 1'b1, 1'b0, 1'b1);
    step(SRL, 16'h8001, 16'h0000, 16'h0000, 4'd0, 1'b0);
    expect_all("srl_d0", 16'h8001, 1'b0, 1'b0, 1'b0);
    step(SLO, 16'h0004, 16'h0000, 16'h0000, 4'd4, 1'b0);
    expect_all("slo4", 16'h004F, 1'b0, 1'b0, 1'b0);
    step(SRO, 16'h0004, 16'h0000, 16'h0000, 4'd4, 1'b0);
    expect_all("sro4", 16'hF000, 1'b0, 1'b0, 1'b0);

    step(SLG, 16'h1234, 16'h0000, 16'hABCD, 4'd4, 1'b0);
    expect_all("slg4", 16'h234A, 1'b0, 1'b0, 1'b0);
    step(SRG, 16'h1234, 16'h0000, 16'hABCD, 4'd4, 1'b0);
    expect_all("srg4", 16'hD123, 1'b0, 1'b0, 1'b0);
    step(SLG, 16'h1234, 16'h0000, 16'hABCD, 4'd0, 1'b0);
    expect_all("slg_d0", 16'h1234, 1'b0, 1'b0, 1'b0);
    step(SRG, 16'h1234, 16'h0000, 16'hABCD, 4'd0, 1'b0);
    expect_all("srg_d0", 16'h1234, 1'b0, 1'b0, 1'b0);
    step(SRG, 16'h1234, 16'h0000, 16'hABCD, 4'd15, 1'b0);
    expect_all("srg15", 16'h579A, 1'b0, 1'b0, 1'b0);

    step(LT,  16'hFFFF, 16'h0001, 16'h0000, 4'd0, 1'b1);
    expect_all("lt_signed", 16'h0001, 1'b0, 1'b0, 1'b0);
    step(GT,  16'hFFFF, 16'h0001, 16'h0000, 4'd0, 1'b1);
    expect_all("gt_signed", 16'h0000, 1'b1, 1'b0, 1'b0);
    step(NEG, 16'h8000, 16'h0000, 16'h0000, 4'd0, 1'b1);
    expect_all("neg_min", 16'h8000, 1'b0, 1'b0, 1'b0);
    step(4'd13, 16'h0001, 16'h0001, 16'hFFFF, 4'd3, 1'b1);
    expect_all("reserved13", 16'h0000, 1'b1, 1'b1, 1'b0);
    step(4'd15, 16'hFFFF, 16'h0001, 16'hFFFF, 4'd1, 1'b1);
    expect_all("reserved15", 16'h0000, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream discards the operation presented with it.
    reset = 1'b1;
    step(ADD, 16'h0001, 16'h0001, 16'h0000, 4'd0, 1'b0);
    expect_all("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(ADD, 16'h0001, 16'h0002, 16'h0000, 4'd0, 1'b0);
    expect_all("after_rst", 16'h0003, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
